// File: rtl/barrett_mu_gen_pkg.sv
// Shared constants for the Barrett constant generator: default widths,
// FSM state encoding and the smallest modulus that yields a usable mu.
package barrett_mu_gen_pkg;

    localparam int Q_W_DEF  = 64;
    localparam int MU_W_DEF = Q_W_DEF + 2;
    localparam int K_W_DEF  = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // q = 0 or 1 has no meaningful Barrett constant
    localparam int unsigned Q_MIN = 32'd2;

endpackage : barrett_mu_gen_pkg

// File: rtl/barrett_mu_gen_bitlen_lod.sv
// Leading-one detector: returns the bit length of q (MS one index + 1),
// or 0 when q is zero.
module barrett_mu_gen_bitlen_lod #(
    parameter int Q_W = 64,
    parameter int K_W = 7
) (
    input  logic [Q_W-1:0] q,
    output logic [K_W-1:0] k
);

    logic [K_W-1:0] k_s;

    // scan upward so the highest set bit wins
    always_comb begin
        k_s = {K_W{1'b0}};
        for (int i = 0; i < Q_W; i++) begin
            k_s = q[i] ? K_W'(i + 1) : k_s;
        end
    end

    assign k = k_s;

endmodule : barrett_mu_gen_bitlen_lod

// File: rtl/barrett_mu_gen.sv
// Barrett constant generator: k = bitlen(q), r = 2^k, mu = floor(2^(2k)/q),
// computed by a restoring divider producing one quotient bit per clock.
module barrett_mu_gen
    import barrett_mu_gen_pkg::*;
#(
    parameter int Q_W  = Q_W_DEF,
    parameter int MU_W = Q_W + 2,
    parameter int K_W  = K_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [Q_W-1:0]  q_in,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [K_W-1:0]  k_out,
    output logic [Q_W:0]    r_out,
    output logic [MU_W-1:0] mu_out
);

    localparam int CNT_W = K_W + 1;

    logic [1:0]       state_r;
    logic [Q_W-1:0]   q_r;
    logic [Q_W:0]     rem_r;
    logic [MU_W-1:0]  quo_r;
    logic [CNT_W-1:0] cnt_r;
    logic [K_W-1:0]   k_r;
    logic [Q_W:0]     r_r;

    logic [K_W-1:0]   lod_k_s;
    logic [Q_W:0]     t_s;
    logic [Q_W:0]     diff_s;
    logic             ge_s;
    logic [Q_W:0]     rem_next_s;
    logic [MU_W-1:0]  quo_next_s;
    logic             q_small_s;

    barrett_mu_gen_bitlen_lod #(
        .Q_W (Q_W),
        .K_W (K_W)
    ) u_lod (
        .q (q_r),
        .k (lod_k_s)
    );

    // rem < q < 2^Q_W, so its top bit is always zero and the shift fits Q_W+1 bits
    assign t_s        = {rem_r[Q_W-1:0], 1'b0};
    assign ge_s       = (t_s >= {1'b0, q_r});
    assign diff_s     = t_s - {1'b0, q_r};
    assign rem_next_s = ge_s ? diff_s : t_s;
    assign quo_next_s = {quo_r[MU_W-2:0], ge_s};
    assign q_small_s  = (q_in < Q_W'(Q_MIN));

    // FSM, divider datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            q_r     <= {Q_W{1'b0}};
            rem_r   <= {(Q_W+1){1'b0}};
            quo_r   <= {MU_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            k_r     <= {K_W{1'b0}};
            r_r     <= {(Q_W+1){1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            k_out   <= {K_W{1'b0}};
            r_out   <= {(Q_W+1){1'b0}};
            mu_out  <= {MU_W{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        q_r <= q_in;
                        if (q_small_s) begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            k_out   <= {K_W{1'b0}};
                            r_out   <= {(Q_W+1){1'b0}};
                            mu_out  <= {MU_W{1'b0}};
                        end else begin
                            state_r <= ST_LOAD;
                            busy    <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // dividend 2^(2k): its leading 1 is preloaded into rem
                    k_r     <= lod_k_s;
                    r_r     <= {{Q_W{1'b0}}, 1'b1} << lod_k_s;
                    rem_r   <= {{Q_W{1'b0}}, 1'b1};
                    quo_r   <= {MU_W{1'b0}};
                    cnt_r   <= {lod_k_s, 1'b0};
                    state_r <= ST_DIV;
                    busy    <= 1'b1;
                end
                ST_DIV: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        k_out   <= k_r;
                        r_out   <= r_r;
                        mu_out  <= quo_next_s;
                    end else begin
                        state_r <= ST_DIV;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : barrett_mu_gen

// File: tb/tb_barrett_mu_gen.sv
// Directed bench for barrett_mu_gen: table of moduli with hand-computed
// k/r/mu/latency, plus restart-while-busy, back-to-back and mid-run reset.
module tb_barrett_mu_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] q_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  k_out;
    logic [64:0] r_out;
    logic [65:0] mu_out;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] q;
        int          k;
        logic [64:0] r;
        logic [65:0] mu;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    barrett_mu_gen dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .q_in   (q_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .k_out  (k_out),
        .r_out  (r_out),
        .mu_out (mu_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller raises start at a negedge during cycle c0; returns the cycle done is seen, -1 on timeout.
    task automatic wait_done(input int c0, output int lat);
        lat = -1;
        for (int c = c0 + 1; c <= c0 + 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{64'd7681, 13, 65'd8192, 66'd8736, 1'b0, 28};
        vecs[1] = '{64'd3, 2, 65'd4, 66'd5, 1'b0, 6};
        vecs[2] = '{64'd4, 3, 65'd8, 66'd16, 1'b0, 8};
        vecs[3] = '{64'd2, 2, 65'd4, 66'd8, 1'b0, 6};
        vecs[4] = '{64'd5, 3, 65'd8, 66'd12, 1'b0, 8};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 65'h1_0000_0000_0000_0000,
                    66'h1_0000_0000_0000_0001, 1'b0, 130};
        vecs[6] = '{64'h8000_0000_0000_0000, 64, 65'h1_0000_0000_0000_0000,
                    66'h2_0000_0000_0000_0000, 1'b0, 130};
        vecs[7] = '{64'd1, 0, 65'd0, 66'd0, 1'b1, 1};
        vecs[8] = '{64'd0, 0, 65'd0, 66'd0, 1'b1, 1};
        vecs[9] = '{64'd7681, 13, 65'd8192, 66'd8736, 1'b0, 28};

        rst   = 1'b1;
        start = 1'b0;
        q_in  = 64'd0;
        repeat (3) @(negedge clk);
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset done", 128'(done), 128'(0));
        chk("reset err", 128'(err), 128'(0));
        chk("reset k", 128'(k_out), 128'(0));
        chk("reset r", 128'(r_out), 128'(0));
        chk("reset mu", 128'(mu_out), 128'(0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            start = 1'b1;
            q_in  = vecs[i].q;
            wait_done(0, lat);
            chk($sformatf("v%0d q=%0h latency", i, vecs[i].q), 128'(lat), 128'(vecs[i].lat));
            chk($sformatf("v%0d q=%0h k", i, vecs[i].q), 128'(k_out), 128'(vecs[i].k));
            chk($sformatf("v%0d q=%0h r", i, vecs[i].q), 128'(r_out), 128'(vecs[i].r));
            chk($sformatf("v%0d q=%0h mu", i, vecs[i].q), 128'(mu_out), 128'(vecs[i].mu));
            chk($sformatf("v%0d q=%0h err", i, vecs[i].q), 128'(err), 128'(vecs[i].err));
            chk($sformatf("v%0d busy at done", i), 128'(busy), 128'(0));
            @(negedge clk);
            chk($sformatf("v%0d done pulse width", i), 128'(done), 128'(0));
        end

        // start re-pulsed mid-division with a different q must be ignored
        @(negedge clk);
        start = 1'b1;
        q_in  = 64'd7681;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b1;
        q_in  = 64'd3;
        wait_done(5, lat);
        chk("restart ignored latency", 128'(lat), 128'(28));
        chk("restart ignored mu", 128'(mu_out), 128'(8736));
        chk("restart ignored k", 128'(k_out), 128'(13));

        // back-to-back: start accepted in the DONE cycle
        @(negedge clk);
        start = 1'b1;
        q_in  = 64'd3;
        wait_done(0, lat);
        chk("b2b first mu", 128'(mu_out), 128'(5));
        start = 1'b1;
        q_in  = 64'd7681;
        @(negedge clk);
        start = 1'b0;
        chk("b2b busy after start", 128'(busy), 128'(1));
        chk("b2b k held", 128'(k_out), 128'(2));
        chk("b2b mu held", 128'(mu_out), 128'(5));
        wait_done(1, lat);
        chk("b2b second latency", 128'(lat), 128'(28));
        chk("b2b second mu", 128'(mu_out), 128'(8736));

        // reset mid-division aborts without a done pulse
        @(negedge clk);
        start = 1'b1;
        q_in  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 128'(busy), 128'(0));
        chk("midrst done", 128'(done), 128'(0));
        chk("midrst k", 128'(k_out), 128'(0));
        chk("midrst r", 128'(r_out), 128'(0));
        chk("midrst mu", 128'(mu_out), 128'(0));
        seen = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("midrst no done afterwards", 128'(seen), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_barrett_mu_gen
